div_array_share_ctrl: RTL and testbench
=======================================

// Module: div_array_share_ctrl
// PURPOSE
//  Shares one combinational 16/8 array-divider core (exact or approximate variant) among
//  NUM_REQ requesters. Round-robin arbitration, valid/ready handshakes on both sides,
//  operand registers, a multi-cycle settle window for the deep ripple-borrow array,
//  and divide-by-zero / quotient-overflow screening before the core is used.
//  Sits between the requesting engines and the divider core. The core is external and
//  connected via the div_* ports.
// PARAMETERS
//  NUM_REQ     4  number of requesters, >=1
//  SETTLE_CYC  3  cycles operands are held stable before div_q/div_r are sampled, >=1
//  IDW         $clog2(NUM_REQ) (min 1)  width of rsp_id, localparam
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             synchronous, active-high reset
//  req_valid  in   NUM_REQ       per-requester request valid
//  req_ready  out  NUM_REQ       per-requester accept; one-hot or zero
//  req_n      in   16*NUM_REQ    dividends, requester k at [16k+15:16k]
//  req_d      in   8*NUM_REQ     divisors, requester k at [8k+7:8k]
//  rsp_valid  out  1             response valid
//  rsp_ready  in   1             response accept
//  rsp_id     out  IDW           index of the served requester
//  rsp_q      out  8             quotient
//  rsp_r      out  8             remainder
//  rsp_dbz    out  1             divide-by-zero flag
//  rsp_ovf    out  1             quotient-overflow flag
//  div_n      out  16            dividend to the core
//  div_d      out  8             divisor to the core
//  div_q      in   8             quotient from the core
//  div_r      in   8             remainder from the core
//  busy       out  1             high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, rr pointer=0. All outputs 0, including the div_n/div_d operand registers.
//  - FSM states: IDLE -> SETTLE -> RESP -> IDLE; IDLE -> RESP on a screened request.
//  - IDLE, arbitration: grant = first req_valid at or after the pointer, wrapping at NUM_REQ.
//    - req_ready[grant] is asserted combinationally only in IDLE.
//    - On req_valid & req_ready: latch n, d and id, and set pointer <= (grant+1) mod NUM_REQ.
//    - A requester dropping req_valid before it is accepted is legal. No state is kept for it.
//  - Screening, done on the accept edge, in priority order:
//    - d==0: go to RESP with dbz=1, q=8'hFF, r=n[7:0].
//    - n[15:8]>=d: go to RESP with ovf=1, q=8'hFF, r=8'hFF.
//    - Otherwise: go to SETTLE and load cnt=SETTLE_CYC.
//  - div_n/div_d are driven from the operand registers and stay stable from accept until the
//    next accept.
//  - SETTLE: decrement cnt each cycle. On cnt==1, sample div_q/div_r into the rsp registers,
//    clear both flags, and go to RESP.
//  - Latency, with accept in cycle t:
//    - Screened requests: rsp_valid first high in cycle t+1.
//    - Normal requests: rsp_valid first high in cycle t+1+SETTLE_CYC.
//  - RESP: rsp_valid=1. rsp_id, rsp_q, rsp_r and the flags hold stable until rsp_ready.
//    - On the handshake: go to IDLE and drop rsp_valid next cycle.
//    - No request is accepted in the cycle of the rsp handshake. At most one request is in flight.
//  - rst asserted mid-operation aborts the in-flight request:
//    - no response is ever produced for it;
//    - the pointer returns to 0;
//    - outputs are as at reset in the following cycle.
//  - NUM_REQ==1: the arbiter degenerates to a pass-through and rsp_id is constant 0.
// STRUCTURE
//  - Shared package div_ctrl_pkg:
//    - widths N_W=16, D_W=8, Q_W=8;
//    - state enum {IDLE, SETTLE, RESP};
//    - saturation constants Q_SAT=8'hFF, R_SAT=8'hFF.
//  - One sub-module, rr_arbiter #(N):
//    - inputs: request vector, pointer; outputs: one-hot grant, grant index, any_req;
//    - purely combinational; the pointer register lives in the parent.
//  - Everything else (FSM, counter, operand/response registers) lives in div_array_share_ctrl.
// TESTING
//  The bench uses an exact behavioural divider stub on the div_* ports; approximate cores are
//  checked against their own golden model. All cases use NUM_REQ=4, SETTLE_CYC=3.
//  1. req 0: n=100, d=7, accepted in cycle t -> rsp_valid at t+4: id=0, q=14, r=2, dbz=0, ovf=0.
//  2. req 2: n=16'h1234, d=0 -> rsp_valid at t+1: dbz=1, ovf=0, q=8'hFF, r=8'h34; core never sampled.
//  3. req 1: n=16'h0800, d=8 -> rsp_valid at t+1: ovf=1, q=8'hFF, r=8'hFF.
//  4. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1, one accept per transaction.
//  5. rsp_ready low for 10 cycles in RESP -> rsp fields stable, req_ready all 0, busy=1;
//     release -> IDLE on the next cycle.
//  6. rst pulsed in the 2nd SETTLE cycle -> next cycle IDLE, all outputs 0, no response;
//     next grant goes to requester 0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared widths, FSM state encoding and saturation constants for the
// shared array-divider controller.
package div_ctrl_pkg;

    localparam int N_W = 16;
    localparam int D_W = 8;
    localparam int Q_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [Q_W-1:0] Q_SAT = 8'hFF;
    localparam logic [Q_W-1:0] R_SAT = 8'hFF;

endpackage

// File: rtl/div_array_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after
// ptr, wrapping at N. The pointer register is owned by the parent.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    // Scan the upper segment [ptr..N-1] first, then wrap to [0..ptr-1].
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any_req && req[j] && (j >= int'(ptr))) begin
                any_req   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any_req && req[j] && (j < int'(ptr))) begin
                any_req   = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/div_array_share_ctrl.sv
// Shares one external combinational 16/8 array divider among NUM_REQ
// requesters: round-robin accept, zero/overflow screening, a settle window
// for the ripple-borrow array, and a held response until rsp_ready.
module div_array_share_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  SETTLE_CYC = 3,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [N_W*NUM_REQ-1:0] req_n,
    input  logic [D_W*NUM_REQ-1:0] req_d,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [Q_W-1:0]         rsp_q,
    output logic [Q_W-1:0]         rsp_r,
    output logic                   rsp_dbz,
    output logic                   rsp_ovf,
    output logic [N_W-1:0]         div_n,
    output logic [D_W-1:0]         div_d,
    input  logic [Q_W-1:0]         div_q,
    input  logic [Q_W-1:0]         div_r,
    output logic                   busy
);

    localparam int CW = $clog2(SETTLE_CYC + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_next;
    logic [IDW-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic             any_req;
    logic             accept;
    logic [N_W-1:0]   sel_n;
    logic [D_W-1:0]   sel_d;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // A grant is only offered while idle, so at most one request is in flight.
    assign accept    = (state == IDLE) && any_req && !rst;
    assign req_ready = accept ? grant : '0;
    assign sel_n     = req_n[N_W*grant_idx +: N_W];
    assign sel_d     = req_d[D_W*grant_idx +: D_W];
    assign ptr_next  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    // FSM, operand registers, settle counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            div_n   <= '0;
            div_d   <= '0;
            rsp_id  <= '0;
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_dbz <= 1'b0;
            rsp_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr    <= ptr_next;
                        div_n  <= sel_n;
                        div_d  <= sel_d;
                        rsp_id <= grant_idx;
                        if (sel_d == '0) begin
                            state   <= RESP;
                            rsp_dbz <= 1'b1;
                            rsp_ovf <= 1'b0;
                            rsp_q   <= Q_SAT;
                            rsp_r   <= sel_n[Q_W-1:0];
                        end else if (sel_n[N_W-1:D_W] >= sel_d) begin
                            state   <= RESP;
                            rsp_dbz <= 1'b0;
                            rsp_ovf <= 1'b1;
                            rsp_q   <= Q_SAT;
                            rsp_r   <= R_SAT;
                        end else begin
                            state <= SETTLE;
                            cnt   <= CW'(SETTLE_CYC);
                        end
                    end
                end
                SETTLE: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state   <= RESP;
                        rsp_q   <= div_q;
                        rsp_r   <= div_r;
                        rsp_dbz <= 1'b0;
                        rsp_ovf <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_array_share_ctrl.sv
// Directed bench for div_array_share_ctrl with an exact divider stub.
module tb_div_array_share_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_n;
    logic [31:0] req_d;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_q;
    logic [7:0]  rsp_r;
    logic        rsp_dbz;
    logic        rsp_ovf;
    logic [15:0] div_n;
    logic [7:0]  div_d;
    logic [7:0]  div_q;
    logic [7:0]  div_r;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int lat;
    int seen;

    logic [7:0] exp_q [4];
    logic [7:0] exp_r [4];

    div_array_share_ctrl #(.NUM_REQ(4), .SETTLE_CYC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .rsp_ovf   (rsp_ovf),
        .div_n     (div_n),
        .div_d     (div_d),
        .div_q     (div_q),
        .div_r     (div_r),
        .busy      (busy)
    );

    // Exact behavioural divider core.
    always_comb begin
        div_q = 8'h00;
        div_r = 8'h00;
        if (div_d != 8'h00) begin
            div_q = 8'(div_n / {8'h00, div_d});
            div_r = 8'(div_n % {8'h00, div_d});
        end
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int k, input logic [15:0] n, input logic [7:0] d);
        req_n[16*k +: 16] = n;
        req_d[8*k +: 8]   = d;
    endtask

    // Called in the cycle after accept; returns cycles from accept to rsp_valid.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_output("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("post_rsp_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_n     = '0;
        req_d     = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_div_n", 32'(div_n), 32'd0);
        check_output("rst_div_d", 32'(div_d), 32'd0);
        check_output("rst_rsp_q", 32'(rsp_q), 32'd0);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);

        // Case 1: normal divide 100/7 from requester 0.
        apply_stimulus(0, 16'd100, 8'd7);
        req_valid = 4'b0001;
        #1;
        check_output("c1_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check_output("c1_busy", 32'(busy), 32'd1);
        check_output("c1_div_n", 32'(div_n), 32'd100);
        check_output("c1_div_d", 32'(div_d), 32'd7);
        wait_rsp(lat);
        check_output("c1_latency", 32'(lat), 32'd4);
        check_output("c1_id", 32'(rsp_id), 32'd0);
        check_output("c1_q", 32'(rsp_q), 32'd14);
        check_output("c1_r", 32'(rsp_r), 32'd2);
        check_output("c1_dbz", 32'(rsp_dbz), 32'd0);
        check_output("c1_ovf", 32'(rsp_ovf), 32'd0);
        finish_rsp();

        // Case 2: divide by zero from requester 2.
        apply_stimulus(2, 16'h1234, 8'd0);
        req_valid = 4'b0100;
        #1;
        check_output("c2_req_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        wait_rsp(lat);
        check_output("c2_latency", 32'(lat), 32'd1);
        check_output("c2_id", 32'(rsp_id), 32'd2);
        check_output("c2_dbz", 32'(rsp_dbz), 32'd1);
        check_output("c2_ovf", 32'(rsp_ovf), 32'd0);
        check_output("c2_q", 32'(rsp_q), 32'hFF);
        check_output("c2_r", 32'(rsp_r), 32'h34);
        check_output("c2_div_n", 32'(div_n), 32'h1234);
        finish_rsp();

        // Case 3: quotient overflow from requester 1 (pointer wraps from 3).
        apply_stimulus(1, 16'h0800, 8'd8);
        req_valid = 4'b0010;
        #1;
        check_output("c3_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_rsp(lat);
        check_output("c3_latency", 32'(lat), 32'd1);
        check_output("c3_id", 32'(rsp_id), 32'd1);
        check_output("c3_ovf", 32'(rsp_ovf), 32'd1);
        check_output("c3_dbz", 32'(rsp_dbz), 32'd0);
        check_output("c3_q", 32'(rsp_q), 32'hFF);
        check_output("c3_r", 32'(rsp_r), 32'hFF);
        finish_rsp();

        // Case 4: all requesters active, pointer reset to 0 -> order 0,1,2,3,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply_stimulus(0, 16'd50, 8'd5);
        apply_stimulus(1, 16'd61, 8'd5);
        apply_stimulus(2, 16'd72, 8'd5);
        apply_stimulus(3, 16'd83, 8'd5);
        exp_q[0] = 8'd10; exp_r[0] = 8'd0;
        exp_q[1] = 8'd12; exp_r[1] = 8'd1;
        exp_q[2] = 8'd14; exp_r[2] = 8'd2;
        exp_q[3] = 8'd16; exp_r[3] = 8'd3;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int t = 0; t < 6; t++) begin
            check_output("c4_grant", 32'(req_ready), 32'(4'b0001 << (t % 4)));
            tick();
            check_output("c4_no_ready", 32'(req_ready), 32'd0);
            wait_rsp(lat);
            check_output("c4_latency", 32'(lat), 32'd4);
            check_output("c4_id", 32'(rsp_id), 32'(t % 4));
            check_output("c4_q", 32'(rsp_q), 32'(exp_q[t % 4]));
            check_output("c4_r", 32'(rsp_r), 32'(exp_r[t % 4]));
            tick();
        end

        // Case 5: backpressure in RESP for 10 cycles (grant 2 expected).
        rsp_ready = 1'b0;
        #1;
        check_output("c5_grant", 32'(req_ready), 32'h4);
        tick();
        wait_rsp(lat);
        check_output("c5_latency", 32'(lat), 32'd4);
        for (int c = 0; c < 10; c++) begin
            check_output("c5_valid", 32'(rsp_valid), 32'd1);
            check_output("c5_id", 32'(rsp_id), 32'd2);
            check_output("c5_q", 32'(rsp_q), 32'd14);
            check_output("c5_r", 32'(rsp_r), 32'd2);
            check_output("c5_req_ready", 32'(req_ready), 32'd0);
            check_output("c5_busy", 32'(busy), 32'd1);
            tick();
        end
        req_valid = '0;
        finish_rsp();

        // Case 6: reset in the second SETTLE cycle aborts the request.
        apply_stimulus(1, 16'd100, 8'd7);
        req_valid = 4'b0010;
        #1;
        check_output("c6_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        check_output("c6_settle_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("c6_busy", 32'(busy), 32'd0);
        check_output("c6_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("c6_div_n", 32'(div_n), 32'd0);
        check_output("c6_div_d", 32'(div_d), 32'd0);
        check_output("c6_rsp_q", 32'(rsp_q), 32'd0);
        check_output("c6_rsp_id", 32'(rsp_id), 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check_output("c6_no_rsp", 32'(seen), 32'd0);
        req_valid = 4'b1111;
        #1;
        check_output("c6_ptr_zero", 32'(req_ready), 32'h1);
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
